// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the instruction/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RD_WAIT
    } arb_state_t;

    typedef enum logic {
        PORT_IF,
        PORT_D
    } arb_port_t;

    // Deepest memory read pipeline the latency counter is sized for.
    localparam int MAX_RD_LAT = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch (IF) and load/store (D).
// Latency: grant is combinational with the request; read data returns RD_LAT cycles after grant.
// Backpressure: requests must be held until GNT; no grant while a read is outstanding except in its final cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IF_REQ,
    input  logic [ADDR_W-1:0]     IF_ADDR,
    output logic                  IF_GNT,
    output logic                  IF_RVALID,
    output logic [DATA_W-1:0]     IF_RDATA,
    input  logic                  D_REQ,
    input  logic                  D_WE,
    input  logic [ADDR_W-1:0]     D_ADDR,
    input  logic [DATA_W-1:0]     D_WDATA,
    input  logic [DATA_W/8-1:0]   D_BE,
    output logic                  D_GNT,
    output logic                  D_RVALID,
    output logic [DATA_W-1:0]     D_RDATA,
    output logic                  M_EN,
    output logic                  M_WE,
    output logic [ADDR_W-1:0]     M_ADDR,
    output logic [DATA_W-1:0]     M_WDATA,
    output logic [DATA_W/8-1:0]   M_BE,
    input  logic [DATA_W-1:0]     M_RDATA,
    output logic                  BUSY
);

    localparam int                CNT_W    = $clog2(MAX_RD_LAT + 1);
    localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
        $error("mem_port_arbiter: RD_LAT must be in 1..%0d", MAX_RD_LAT);
    end

    arb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    arb_port_t         owner, owner_nxt;
    arb_port_t         last_winner, last_winner_nxt;
    arb_port_t         win;
    logic              grant_ok;
    logic              rd_done;

    // Round-robin chooser: on a conflict the port that did not win last time
    // goes first; otherwise whichever port is requesting.
    function automatic arb_port_t rr_pick(input logic       if_req,
                                          input logic       d_req,
                                          input arb_port_t  last);
        if (if_req && d_req) begin
            return (last == PORT_IF) ? PORT_D : PORT_IF;
        end else if (d_req) begin
            return PORT_D;
        end else begin
            return PORT_IF;
        end
    endfunction

    // State register: reset drops any in-flight read and biases the first conflict to IF.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            owner       <= PORT_IF;
            last_winner <= PORT_D;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            owner       <= owner_nxt;
            last_winner <= last_winner_nxt;
        end
    end

    // Grant decision, memory drive, read return and next-state; everything is
    // held at zero while reset is asserted so nothing leaks from a dropped read.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        owner_nxt       = owner;
        last_winner_nxt = last_winner;
        win             = PORT_IF;
        IF_GNT          = 1'b0;
        D_GNT           = 1'b0;
        IF_RVALID       = 1'b0;
        D_RVALID        = 1'b0;
        IF_RDATA        = '0;
        D_RDATA         = '0;
        M_EN            = 1'b0;
        M_WE            = 1'b0;
        M_ADDR          = '0;
        M_WDATA         = '0;
        M_BE            = '0;

        rd_done  = !RST && (state == ST_RD_WAIT) && (cnt == CNT_ONE);
        grant_ok = !RST && ((state == ST_IDLE) || rd_done);
        BUSY     = !RST && (state == ST_RD_WAIT);

        if (rd_done) begin
            if (owner == PORT_IF) begin
                IF_RVALID = 1'b1;
                IF_RDATA  = M_RDATA;
            end else begin
                D_RVALID  = 1'b1;
                D_RDATA   = M_RDATA;
            end
        end

        // Count down the outstanding read; a grant below may override this
        // with a back-to-back reload.
        if (state == ST_RD_WAIT) begin
            if (cnt == CNT_ONE) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt   = cnt - CNT_ONE;
            end
        end

        if (grant_ok && (IF_REQ || D_REQ)) begin
            win             = rr_pick(IF_REQ, D_REQ, last_winner);
            last_winner_nxt = win;
            M_EN            = 1'b1;
            if (win == PORT_IF) begin
                IF_GNT = 1'b1;
                M_ADDR = IF_ADDR;
            end else begin
                D_GNT   = 1'b1;
                M_ADDR  = D_ADDR;
                M_WE    = D_WE;
                M_WDATA = D_WDATA;
                M_BE    = D_BE;
            end
            // Writes finish in the grant cycle; only reads occupy the port.
            if ((win == PORT_IF) || !D_WE) begin
                owner_nxt = win;
                cnt_nxt   = LAT_LOAD;
                state_nxt = ST_RD_WAIT;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a behavioural memory and arbitration model.
// Latency: checks grant/memory strobes each cycle and read returns exactly RD_LAT cycles after grant.
// Backpressure: requesters hold each request until the model says it was granted.
module tb_mem_port_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LAT = 3;

    logic           CLK = 1'b0;
    logic           RST;
    logic           IF_REQ;
    logic [AW-1:0]  IF_ADDR;
    logic           IF_GNT, IF_RVALID;
    logic [DW-1:0]  IF_RDATA;
    logic           D_REQ, D_WE;
    logic [AW-1:0]  D_ADDR;
    logic [DW-1:0]  D_WDATA;
    logic [BW-1:0]  D_BE;
    logic           D_GNT, D_RVALID;
    logic [DW-1:0]  D_RDATA;
    logic           M_EN, M_WE;
    logic [AW-1:0]  M_ADDR;
    logic [DW-1:0]  M_WDATA;
    logic [BW-1:0]  M_BE;
    logic [DW-1:0]  M_RDATA;
    logic           BUSY;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT),
        .IF_RVALID(IF_RVALID), .IF_RDATA(IF_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_BE(D_BE),
        .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
        .M_EN(M_EN), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_BE(M_BE),
        .M_RDATA(M_RDATA), .BUSY(BUSY)
    );

    typedef struct {
        bit             port;   // 0 = IF, 1 = D
        logic [DW-1:0]  data;
        int             due;
    } rsp_t;

    typedef struct {
        logic           we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [BW-1:0]  be;
    } dop_t;

    rsp_t           sb[$];
    dop_t           d_ops[$];
    logic [AW-1:0]  if_ops[$];

    int             errors = 0;
    int             checks = 0;
    int             cyc    = 0;

    logic [DW-1:0]  sram    [64];
    logic [DW-1:0]  ref_mem [64];
    logic [DW-1:0]  pipe    [LAT];

    // Reference model: one outstanding read at most, finishing at cycle 'due'.
    bit             outst  = 1'b0;
    int             due    = 0;
    bit             last_d = 1'b1;
    bit             g_if, g_d;
    bit             random_gaps = 1'b0;
    bit             if_on = 1'b0, d_on = 1'b0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_reqs();
        if (!if_on && if_ops.size() > 0 && (!random_gaps || $urandom_range(0, 2) != 0)) if_on = 1'b1;
        if (!d_on && d_ops.size() > 0 && (!random_gaps || $urandom_range(0, 2) != 0)) d_on = 1'b1;
        IF_REQ  = if_on;
        IF_ADDR = if_on ? if_ops[0] : AW'($urandom);
        D_REQ   = d_on;
        D_WE    = d_on ? d_ops[0].we    : 1'($urandom);
        D_ADDR  = d_on ? d_ops[0].addr  : AW'($urandom);
        D_WDATA = d_on ? d_ops[0].wdata : $urandom;
        D_BE    = d_on ? d_ops[0].be    : BW'($urandom);
    endtask

    // One clock cycle: drive, predict and compare at the negedge, then advance
    // the memory model and requesters just after the posedge.
    task automatic cycle();
        logic           e_en, e_we, e_busy, cang;
        logic [AW-1:0]  e_addr;
        logic [DW-1:0]  e_wd;
        logic [BW-1:0]  e_be;
        logic           s_en, s_we;
        logic [AW-1:0]  s_addr;
        logic [DW-1:0]  s_wd;
        logic [BW-1:0]  s_be;

        drive_reqs();
        @(negedge CLK);
        g_if = 1'b0; g_d = 1'b0;
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_be = '0;
        e_busy = !RST && outst;
        if (RST) begin
            outst  = 1'b0;
            last_d = 1'b1;
            sb.delete();
        end else begin
            cang = !outst || (cyc == due);
            if (outst && cyc == due) outst = 1'b0;
            if (cang && (IF_REQ || D_REQ)) begin
                g_d    = (IF_REQ && D_REQ) ? !last_d : D_REQ;
                g_if   = !g_d;
                last_d = g_d;
                e_en   = 1'b1;
                if (g_if) begin
                    e_addr = IF_ADDR;
                    sb.push_back('{1'b0, ref_mem[IF_ADDR[5:0]], cyc + LAT});
                    outst = 1'b1; due = cyc + LAT;
                end else begin
                    e_addr = D_ADDR; e_we = D_WE; e_wd = D_WDATA; e_be = D_BE;
                    if (D_WE) begin
                        ref_mem[D_ADDR[5:0]] = merge(ref_mem[D_ADDR[5:0]], D_WDATA, D_BE);
                    end else begin
                        sb.push_back('{1'b1, ref_mem[D_ADDR[5:0]], cyc + LAT});
                        outst = 1'b1; due = cyc + LAT;
                    end
                end
            end
        end
        chk("if_gnt",  64'(IF_GNT),  64'(g_if));
        chk("d_gnt",   64'(D_GNT),   64'(g_d));
        chk("m_en",    64'(M_EN),    64'(e_en));
        chk("m_we",    64'(M_WE),    64'(e_we));
        chk("m_addr",  64'(M_ADDR),  64'(e_addr));
        chk("m_wdata", 64'(M_WDATA), 64'(e_wd));
        chk("m_be",    64'(M_BE),    64'(e_be));
        chk("busy",    64'(BUSY),    64'(e_busy));
        s_en = M_EN; s_we = M_WE; s_addr = M_ADDR; s_wd = M_WDATA; s_be = M_BE;

        @(posedge CLK);
        #1;
        cyc++;
        for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = (s_en && !s_we) ? sram[s_addr[5:0]] : $urandom;
        if (s_en && s_we) sram[s_addr[5:0]] = merge(sram[s_addr[5:0]], s_wd, s_be);
        M_RDATA = pipe[LAT-1];
        if (g_if) begin void'(if_ops.pop_front()); if_on = 1'b0; end
        if (g_d)  begin void'(d_ops.pop_front());  d_on  = 1'b0; end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((if_ops.size() > 0 || d_ops.size() > 0 || outst || sb.size() > 0) && n < limit) begin
            cycle();
            n++;
        end
        chk("drain_in_budget", 64'(n < limit), 64'(1));
    endtask

    function automatic dop_t rd(input logic [AW-1:0] a);
        return '{1'b0, a, 32'h0, 4'h0};
    endfunction

    // Response monitor: every RVALID must match the oldest expected read, on time.
    initial begin
        rsp_t r;
        forever begin
            @(negedge CLK);
            #2;
            if (IF_RVALID || D_RVALID) begin
                chk("rvalid_onehot", 64'(IF_RVALID && D_RVALID), 64'(0));
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid: got IF=%0b D=%0b expected none (cycle %0d)",
                             IF_RVALID, D_RVALID, cyc);
                end else begin
                    r = sb.pop_front();
                    chk("rsp_cycle", 64'(cyc), 64'(r.due));
                    chk("rsp_port",  64'(D_RVALID), 64'(r.port));
                    chk("rsp_data",  64'(r.port ? D_RDATA : IF_RDATA), 64'(r.data));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                checks++; errors++;
                $display("FAIL missing_rvalid: got none expected port %0d due %0d (cycle %0d)",
                         sb[0].port, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (!IF_RVALID) chk("if_rdata_idle", 64'(IF_RDATA), 64'(0));
            if (!D_RVALID)  chk("d_rdata_idle",  64'(D_RDATA),  64'(0));
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            sram[i]    = {16'hA500 + 16'(i), 16'h5A00 + 16'(i)};
            ref_mem[i] = sram[i];
        end
        for (int i = 0; i < LAT; i++) pipe[i] = $urandom;
        M_RDATA = '0;
        RST = 1'b1;

        // Reset held two cycles with both ports requesting; IF wins first afterwards.
        if_ops.push_back(14'h10);
        d_ops.push_back(rd(14'h20));
        cycle();
        cycle();
        RST = 1'b0;
        drain(50);

        // Streaming fetches.
        if_ops.push_back(14'h10); if_ops.push_back(14'h11); if_ops.push_back(14'h12);
        drain(50);

        // Fetch arriving while a data read is outstanding.
        d_ops.push_back(rd(14'h20));
        cycle();
        if_ops.push_back(14'h3F);
        drain(50);

        // Both ports requesting continuously: grants alternate.
        for (int i = 0; i < 4; i++) begin
            if_ops.push_back(AW'(8 + i));
            d_ops.push_back(rd(AW'(24 + i)));
        end
        drain(80);

        // Partial write then read-back of the merged word; zero-BE write too.
        d_ops.push_back('{1'b1, 14'h30, 32'hDEADBEEF, 4'b0011});
        d_ops.push_back(rd(14'h30));
        d_ops.push_back('{1'b1, 14'h31, 32'h12345678, 4'b0000});
        d_ops.push_back(rd(14'h31));
        drain(50);

        // Reset in the middle of a read drops its response.
        d_ops.push_back(rd(14'h21));
        cycle();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        if_ops.push_back(14'h22);
        drain(50);

        // Randomized traffic with gaps, mixed reads/writes and occasional reset.
        random_gaps = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if (if_ops.size() < 2 && $urandom_range(0, 2) == 0)
                if_ops.push_back(AW'($urandom_range(0, 63)));
            if (d_ops.size() < 2 && $urandom_range(0, 2) == 0)
                d_ops.push_back('{1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 63)),
                                  32'($urandom), BW'($urandom)});
            RST = ($urandom_range(0, 199) == 0);
            cycle();
        end
        RST = 1'b0;
        drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
